piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial "011" sequence detector.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clk on sout, which drives the detector's din.
- Double-buffered (holding register + shift register), so consecutive words stream with no idle gap.
- Provides a bit-valid qualifier and a sent-word counter for bench and system observation.

Parameters:
- WIDTH, 8, data word width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.
- IDLE_LVL, 1'b1, value driven on sout while sout_valid = 0.
- CNT_W, 8, width of the word_cnt counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word (holding register empty).
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a data bit (or parity bit), registered.
- busy  output  1  shifter active or holding register full.
- word_cnt  output  CNT_W  count of fully shifted words; wraps modulo 2^CNT_W.

Behaviour:
- Interfaces: reset reset, asynchronous, active-low; clock clk.
- Reset values: sout = IDLE_LVL, sout_valid = 0, in_ready = 1, busy = 0, word_cnt = 0, state = IDLE, bit counter = 0, holding register empty. Data contents are don't-care.
- Reset mid-word: the current word and any held word are discarded, with no partial completion and no word_cnt increment.
- Handshake:
  - A transfer occurs on a rising edge where in_valid & in_ready = 1.
  - in_ready = !hold_full, and is registered.
  - in_data and in_valid may change freely while in_ready = 0.
  - A word is never dropped or duplicated.
- State machine (states IDLE, SHIFT, plus PAR when the optional feature is enabled):
  - IDLE: on transfer, load the word straight into the shifter and go to SHIFT. The first bit appears on sout with sout_valid = 1 after that same edge (latency 1 clk from the accepting edge).
  - SHIFT: shift one bit per clk; the bit counter runs 0..WIDTH-1.
  - Last bit (counter = WIDTH-1):
    - If the holding register is full, move it into the shifter; stay in SHIFT, counter = 0, no gap.
    - Else if a transfer occurs on this same edge, load the word directly into the shifter; stay in SHIFT.
    - Else go to IDLE; sout returns to IDLE_LVL and sout_valid = 0 after the edge.
  - Transfer while in SHIFT and not on the last bit: the word goes to the holding register (hold_full = 1, in_ready drops after the edge).
- word_cnt increments on the edge that completes a word's final serial bit (final data bit, or parity bit when enabled).
- busy = (state != IDLE) | hold_full.
- Bit order per MSB_FIRST. For 8'h3B with MSB_FIRST = 1: 0,0,1,1,1,0,1,1.
- Sustained throughput: one word per WIDTH clks (WIDTH+1 with parity).

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: after the last data bit, state PAR drives one even-parity bit (XOR of the word) with sout_valid = 1. The last-bit reload rules above apply at the end of PAR instead of at counter = WIDTH-1.
- Undefined: no PAR state, no parity logic; words are exactly WIDTH bits back-to-back.

Decomposition:
- Shared package ser_pkg:
  - State encoding constants: S_IDLE = 2'b00, S_SHIFT = 2'b01, S_PAR = 2'b10.
  - Default WIDTH.
  - Reset-level constant for active-low reset.
- One natural sub-module: ser_shift_reg, the WIDTH-bit loadable shift register with direction select. The FSM, holding register and counters remain in piso_serializer.

Test Plan:
- Single word 8'h3B, MSB_FIRST = 1, idle shifter: accept at edge k → sout = 0,0,1,1,1,0,1,1 on cycles k+1..k+8 with sout_valid high exactly 8 cycles; word_cnt 0 → 1; then sout = 1, sout_valid = 0.
- Back-to-back 8'h00 then 8'hFF with in_valid held high: 16 contiguous valid bits (eight 0s then eight 1s), no gap; in_ready low while the second word is held.
- Backpressure: offer three words during the first word's shift → second is held, third stalls (in_ready = 0) until the hold moves to the shifter; output order is 1, 2, 3; word_cnt = 3.
- Reset asserted at bit 4 of 8'hA5 with a word held → outputs go to reset values immediately (async); word_cnt stays 0; the next accepted word 8'h01 streams correctly.
- word_cnt wrap: send 256 words → word_cnt reads 0 after the last word; 255 after the 255th.
- SER_PARITY_EN defined: 8'h07 → bits 0,0,0,0,0,1,1,1 then parity 1 (9 valid cycles); 8'h03 → parity 0.

Source files
------------

// File: rtl/ser_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ser_pkg : shared state encoding and constants for the serializer  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_PAR   = 2'b10
  } state_t;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic RST_ACTIVE    = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ser_shift_reg : loadable WIDTH-bit shift register, MSB/LSB first  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module ser_shift_reg
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             next_bit
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // next_bit is the bit that will sit at the output end after this edge
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        shreg_d = shreg_q;
        if (load) begin
          shreg_d = load_data;
        end else if (shift) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
      end
      assign next_bit = shreg_d[WIDTH-1];
    end else begin : g_lsb_first
      always_comb begin
        shreg_d = shreg_q;
        if (load) begin
          shreg_d = load_data;
        end else if (shift) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      assign next_bit = shreg_d[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | piso_serializer : double-buffered parallel-in/serial-out stage    |
// | Optional even-parity bit per word when SER_PARITY_EN is defined.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module piso_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = 1'b1,
  parameter int   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int               BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state_q,      state_d;
  logic [BIT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             hold_full_q,  hold_full_d;
  logic             sout_q,       sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             in_ready_q,   in_ready_d;
  logic             busy_q,       busy_d;
  logic [CNT_W-1:0] word_cnt_q,   word_cnt_d;
`ifdef SER_PARITY_EN
  logic             par_q,        par_d;
`endif

  logic             xfer;
  logic             word_done;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_data;
  logic             sh_bit;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_data),
    .shift     (sh_shift),
    .next_bit  (sh_bit)
  );

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_cnt_d  = word_cnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_data     = in_data;
    word_done   = 1'b0;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          sh_load   = 1'b1;
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q != LAST_BIT) begin
          sh_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end else begin
`ifdef SER_PARITY_EN
          state_d   = S_PAR;
`else
          word_done = 1'b1;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        word_done = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Held word has priority at a word boundary; in_ready is low while it is held
    if (word_done) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (hold_full_q) begin
        sh_load     = 1'b1;
        sh_data     = hold_q;
        hold_full_d = 1'b0;
        state_d     = S_SHIFT;
        bit_cnt_d   = '0;
      end else if (xfer) begin
        sh_load     = 1'b1;
        state_d     = S_SHIFT;
        bit_cnt_d   = '0;
      end else begin
        state_d     = S_IDLE;
      end
    end else if (xfer && (state_q != S_IDLE)) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

`ifdef SER_PARITY_EN
    if (sh_load) begin
      par_d = ^sh_data;
    end
`endif
  end

  always_comb begin
    sout_d       = IDLE_LVL;
    sout_valid_d = 1'b0;
    case (state_d)
      S_SHIFT: begin
        sout_d       = sh_bit;
        sout_valid_d = 1'b1;
      end
`ifdef SER_PARITY_EN
      S_PAR: begin
        sout_d       = par_d;
        sout_valid_d = 1'b1;
      end
`endif
      default: begin
        sout_d       = IDLE_LVL;
        sout_valid_d = 1'b0;
      end
    endcase
    in_ready_d = ~hold_full_d;
    busy_d     = (state_d != S_IDLE) | hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      sout_q       <= IDLE_LVL;
      sout_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      word_cnt_q   <= '0;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      word_cnt_q   <= word_cnt_d;
`ifdef SER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign word_cnt   = word_cnt_q;

endmodule
`default_nettype wire
